// File: rtl/axi_write_arb_pkg.sv
// Shared types and constants for the two-requester AXI4 write arbiter.
// Holds requester count/index width, the AW payload bundle and a one-hot helper.
package axi_write_arb_pkg;

    localparam int NUM_REQ   = 2;
    localparam int REQ_IDX_W = 1;
    localparam int AW_ADDR_W = 32;
    localparam int AW_ID_W   = 8;

    typedef struct packed {
        logic [AW_ADDR_W-1:0] addr;
        logic [2:0]           size;
        logic [7:0]           len;
        logic [1:0]           burst;
        logic [AW_ID_W-1:0]   id;
    } aw_payload_t;

    function automatic logic [NUM_REQ-1:0] req_onehot(
        input logic [REQ_IDX_W-1:0] idx
    );
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/axi_write_2to1_arbiter_fifo.sv
// Small FIFO of requester indices recording AW grant order.
// Ports: aclk/aresetn, push/push_data, pop, full, empty, head (oldest entry).
module axi_arb_index_fifo
    import axi_write_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = REQ_IDX_W
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    // Pop is evaluated against the current count, so a pop on a full
    // FIFO does not make room for a push in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];

    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_write_2to1_arbiter.sv
// Two-master to one-slave AXI4 write arbiter: round-robin AW with a
// registered output slot, W routed in grant order, B steered back by order.
// Ports: aclk/aresetn; s_axi_* per-requester slices (req 0 in low bits);
// m_axi_* single write port toward the width converter.
module axi_write_2to1_arbiter
    import axi_write_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            aclk,
    input  logic                            aresetn,

    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [NUM_REQ*3-1:0]            s_axi_awsize,
    input  logic [NUM_REQ*8-1:0]            s_axi_awlen,
    input  logic [NUM_REQ*2-1:0]            s_axi_awburst,
    input  logic [NUM_REQ*ID_WIDTH-1:0]     s_axi_awid,
    input  logic [NUM_REQ-1:0]              s_axi_awvalid,
    output logic [NUM_REQ-1:0]              s_axi_awready,

    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic [NUM_REQ-1:0]              s_axi_wlast,
    input  logic [NUM_REQ-1:0]              s_axi_wvalid,
    output logic [NUM_REQ-1:0]              s_axi_wready,

    output logic [ID_WIDTH-1:0]             s_axi_bid,
    output logic [1:0]                      s_axi_bresp,
    output logic [NUM_REQ-1:0]              s_axi_bvalid,
    input  logic [NUM_REQ-1:0]              s_axi_bready,

    output logic [ADDR_WIDTH-1:0]           m_axi_awaddr,
    output logic [2:0]                      m_axi_awsize,
    output logic [7:0]                      m_axi_awlen,
    output logic [1:0]                      m_axi_awburst,
    output logic [ID_WIDTH-1:0]             m_axi_awid,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,

    output logic [DATA_WIDTH-1:0]           m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]         m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,

    input  logic [ID_WIDTH-1:0]             m_axi_bid,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic                 slot_free;
    logic                 can_accept;
    logic                 aw_hs;
    logic                 w_pop;
    logic                 b_pop;
    logic                 wfull;
    logic                 wempty;
    logic                 bfull;
    logic                 bempty;
    logic [REQ_IDX_W-1:0] last_q;
    logic [REQ_IDX_W-1:0] gnt;
    logic [REQ_IDX_W-1:0] whead;
    logic [REQ_IDX_W-1:0] bhead;

    // The output slot can take a new request when it is empty or being
    // drained this cycle; both order FIFOs need room for the new entry.
    assign slot_free  = !m_axi_awvalid || m_axi_awready;
    assign can_accept = slot_free && !wfull && !bfull;

    // Round-robin: a contested cycle goes to whoever did not win last.
    always_comb begin
        gnt = '0;
        if (&s_axi_awvalid) begin
            gnt = ~last_q;
        end else begin
            gnt = REQ_IDX_W'(s_axi_awvalid[1]);
        end
    end

    assign s_axi_awready = can_accept ? (req_onehot(gnt) & s_axi_awvalid)
                                      : '0;
    assign aw_hs         = |(s_axi_awready & s_axi_awvalid);

    // Registered AW slot; a fresh grant may reload it in the same cycle
    // the converter takes the current one.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awsize  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awburst <= '0;
            m_axi_awid    <= '0;
            last_q        <= REQ_IDX_W'(1);
        end else if (aw_hs) begin
            m_axi_awvalid <= 1'b1;
            m_axi_awaddr  <= s_axi_awaddr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
            m_axi_awsize  <= s_axi_awsize[int'(gnt)*3 +: 3];
            m_axi_awlen   <= s_axi_awlen[int'(gnt)*8 +: 8];
            m_axi_awburst <= s_axi_awburst[int'(gnt)*2 +: 2];
            m_axi_awid    <= s_axi_awid[int'(gnt)*ID_WIDTH +: ID_WIDTH];
            last_q        <= gnt;
        end else if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
        end
    end

    // W path: only the requester at the head of the grant order is
    // connected; everyone else sees wready low until their turn.
    assign m_axi_wdata  = s_axi_wdata[int'(whead)*DATA_WIDTH +: DATA_WIDTH];
    assign m_axi_wstrb  = s_axi_wstrb[int'(whead)*STRB_W +: STRB_W];
    assign m_axi_wlast  = s_axi_wlast[whead];
    assign m_axi_wvalid = !wempty && s_axi_wvalid[whead];
    assign s_axi_wready = (!wempty && m_axi_wready) ? req_onehot(whead)
                                                    : '0;
    assign w_pop        = m_axi_wvalid && m_axi_wready && m_axi_wlast;

    // B path: the slave answers in AW order, so the B FIFO head names
    // the owner. A response with no outstanding burst is never accepted.
    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = (m_axi_bvalid && !bempty) ? req_onehot(bhead)
                                                    : '0;
    assign m_axi_bready = !bempty && s_axi_bready[bhead];
    assign b_pop        = m_axi_bvalid && m_axi_bready;

    axi_arb_index_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (REQ_IDX_W)
    ) u_w_order (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (aw_hs),
        .push_data (gnt),
        .pop       (w_pop),
        .full      (wfull),
        .empty     (wempty),
        .head      (whead)
    );

    axi_arb_index_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (REQ_IDX_W)
    ) u_b_order (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (aw_hs),
        .push_data (gnt),
        .pop       (b_pop),
        .full      (bfull),
        .empty     (bempty),
        .head      (bhead)
    );

endmodule

// File: tb/tb_axi_write_2to1_arbiter.sv
// Randomized directed bench for axi_write_2to1_arbiter with a queue-based
// reference model of grant order, outstanding limits and response routing.
module tb_axi_write_2to1_arbiter;
    import axi_write_arb_pkg::*;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int MO = 4;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic [2*AW-1:0]   s_axi_awaddr;
    logic [5:0]        s_axi_awsize;
    logic [15:0]       s_axi_awlen;
    logic [3:0]        s_axi_awburst;
    logic [2*IW-1:0]   s_axi_awid;
    logic [1:0]        s_axi_awvalid;
    logic [1:0]        s_axi_awready;
    logic [2*DW-1:0]   s_axi_wdata;
    logic [2*DW/8-1:0] s_axi_wstrb;
    logic [1:0]        s_axi_wlast;
    logic [1:0]        s_axi_wvalid;
    logic [1:0]        s_axi_wready;
    logic [IW-1:0]     s_axi_bid;
    logic [1:0]        s_axi_bresp;
    logic [1:0]        s_axi_bvalid;
    logic [1:0]        s_axi_bready;
    logic [AW-1:0]     m_axi_awaddr;
    logic [2:0]        m_axi_awsize;
    logic [7:0]        m_axi_awlen;
    logic [1:0]        m_axi_awburst;
    logic [IW-1:0]     m_axi_awid;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [DW-1:0]     m_axi_wdata;
    logic [DW/8-1:0]   m_axi_wstrb;
    logic              m_axi_wlast;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [IW-1:0]     m_axi_bid;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;

    axi_write_2to1_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awsize(s_axi_awsize),
        .s_axi_awlen(s_axi_awlen), .s_axi_awburst(s_axi_awburst),
        .s_axi_awid(s_axi_awid), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awsize(m_axi_awsize),
        .m_axi_awlen(m_axi_awlen), .m_axi_awburst(m_axi_awburst),
        .m_axi_awid(m_axi_awid), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        logic [63:0] base;
    } burst_t;

    burst_t bur [2][32];
    int nb[2], aw_i[2], w_i[2], beat_i[2], b_i[2];
    bit awhold[2], whold[2];

    bit          pend;
    aw_payload_t pay;
    int          rr_last;
    int          wq[$];
    int          bq[$];

    logic [7:0]  mq_id[$];
    int          m_aw_cnt, wlast_cnt, b_issued;
    bit          bact;
    logic [7:0]  cur_bid;
    logic [1:0]  cur_bresp;

    int pr_awv[2];
    int pr_wv, pr_awr, pr_wr, pr_bv, pr_br;
    int n_cmp, n_err, wbeats, dut_aw_cnt;
    int gnt_log[$];

    function automatic bit rnd(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic logic [63:0] bdata(input int r, input int k,
                                          input int beat);
        return bur[r][k].base + 64'(beat) * 64'h11;
    endfunction

    function automatic logic [7:0] strb_of(input logic [63:0] d);
        return d[7:0] ^ d[15:8];
    endfunction

    function automatic bit all_done();
        return b_i[0] == nb[0] && b_i[1] == nb[1];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int r, input logic [31:0] addr,
                       input int len, input logic [63:0] base);
        bur[r][nb[r]].addr = addr;
        bur[r][nb[r]].len  = 8'(len);
        bur[r][nb[r]].id   = {1'(r), 7'($urandom)};
        bur[r][nb[r]].base = base;
        nb[r]++;
    endtask

    task automatic knobs(input int awv, input int wv, input int awr,
                         input int wr, input int bv, input int br);
        pr_awv[0] = awv; pr_awv[1] = awv;
        pr_wv = wv; pr_awr = awr; pr_wr = wr; pr_bv = bv; pr_br = br;
    endtask

    task automatic new_phase();
        for (int i = 0; i < 2; i++) begin
            nb[i] = 0; aw_i[i] = 0; w_i[i] = 0; beat_i[i] = 0; b_i[i] = 0;
            awhold[i] = 0; whold[i] = 0;
        end
    endtask

    task automatic clear_model();
        pend = 0; pay = '0; rr_last = 1;
        wq.delete(); bq.delete(); mq_id.delete();
        m_aw_cnt = 0; wlast_cnt = 0; b_issued = 0; bact = 0;
        cur_bid = '0; cur_bresp = '0;
        new_phase();
    endtask

    task automatic drive_idle();
        s_axi_awaddr = '0; s_axi_awsize = '0; s_axi_awlen = '0;
        s_axi_awburst = '0; s_axi_awid = '0; s_axi_awvalid = '0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = '0;
        s_axi_wvalid = '0; s_axi_bready = '0;
        m_axi_awready = 0; m_axi_wready = 0;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
    endtask

    task automatic drive();
        logic [63:0] d;
        for (int i = 0; i < 2; i++) begin
            if (aw_i[i] < nb[i]) begin
                s_axi_awvalid[i] = awhold[i] || rnd(pr_awv[i]);
                awhold[i] = s_axi_awvalid[i];
                s_axi_awaddr[i*AW +: AW] = bur[i][aw_i[i]].addr;
                s_axi_awlen[i*8 +: 8]    = bur[i][aw_i[i]].len;
                s_axi_awid[i*IW +: IW]   = bur[i][aw_i[i]].id;
                s_axi_awsize[i*3 +: 3]   = 3'd3;
                s_axi_awburst[i*2 +: 2]  = 2'b01;
            end else begin
                s_axi_awvalid[i] = 1'b0;
            end
            if (w_i[i] < nb[i]) begin
                d = bdata(i, w_i[i], beat_i[i]);
                s_axi_wvalid[i] = whold[i] || rnd(pr_wv);
                whold[i] = s_axi_wvalid[i];
                s_axi_wdata[i*DW +: DW] = d;
                s_axi_wstrb[i*8 +: 8]   = strb_of(d);
                s_axi_wlast[i] = (beat_i[i] == int'(bur[i][w_i[i]].len));
            end else begin
                s_axi_wvalid[i] = 1'b0;
            end
            s_axi_bready[i] = rnd(pr_br);
        end
        m_axi_awready = rnd(pr_awr);
        m_axi_wready  = rnd(pr_wr);
        if (!bact && b_issued < m_aw_cnt && b_issued < wlast_cnt
            && rnd(pr_bv)) begin
            bact      = 1;
            cur_bid   = mq_id[b_issued];
            cur_bresp = rnd(50) ? 2'b10 : 2'b00;
        end
        m_axi_bvalid = bact;
        m_axi_bid    = cur_bid;
        m_axi_bresp  = cur_bresp;
    endtask

    task automatic check_update();
        logic [1:0]  exp_awr, exp_swr, exp_bv;
        logic [63:0] d;
        int g, h, hb;
        bit can, exp_mwv, exp_mbr, aw_hs, maw_hs, w_hs, b_hs;

        can = (!pend || m_axi_awready) && wq.size() < MO && bq.size() < MO;
        g = (s_axi_awvalid == 2'b11) ? 1 - rr_last
                                     : (s_axi_awvalid[1] ? 1 : 0);
        exp_awr = 2'b00;
        if (can && s_axi_awvalid != 2'b00) exp_awr[g] = 1'b1;
        chk("s_awready", 64'(s_axi_awready), 64'(exp_awr));
        chk("m_awvalid", 64'(m_axi_awvalid), 64'(pend));
        if (pend) begin
            chk("m_awaddr", 64'(m_axi_awaddr), 64'(pay.addr));
            chk("m_awlen", 64'(m_axi_awlen), 64'(pay.len));
            chk("m_awid", 64'(m_axi_awid), 64'(pay.id));
            chk("m_awsize", 64'(m_axi_awsize), 64'(pay.size));
            chk("m_awburst", 64'(m_axi_awburst), 64'(pay.burst));
        end

        h = (wq.size() > 0) ? wq[0] : 0;
        exp_mwv = wq.size() > 0 && s_axi_wvalid[h];
        exp_swr = (wq.size() > 0 && m_axi_wready) ? 2'(1 << h) : 2'b00;
        chk("m_wvalid", 64'(m_axi_wvalid), 64'(exp_mwv));
        chk("s_wready", 64'(s_axi_wready), 64'(exp_swr));
        if (exp_mwv) begin
            d = bdata(h, w_i[h], beat_i[h]);
            chk("m_wdata", m_axi_wdata, d);
            chk("m_wstrb", 64'(m_axi_wstrb), 64'(strb_of(d)));
            chk("m_wlast", 64'(m_axi_wlast),
                64'(beat_i[h] == int'(bur[h][w_i[h]].len)));
        end

        hb = (bq.size() > 0) ? bq[0] : 0;
        exp_bv  = (bq.size() > 0 && m_axi_bvalid) ? 2'(1 << hb) : 2'b00;
        exp_mbr = bq.size() > 0 && s_axi_bready[hb];
        chk("s_bvalid", 64'(s_axi_bvalid), 64'(exp_bv));
        chk("m_bready", 64'(m_axi_bready), 64'(exp_mbr));

        if ((s_axi_awready & s_axi_awvalid) != 2'b00) begin
            dut_aw_cnt++;
            gnt_log.push_back(s_axi_awready[1] ? 1 : 0);
        end

        aw_hs  = exp_awr != 2'b00;
        maw_hs = pend && m_axi_awready;
        w_hs   = exp_mwv && m_axi_wready;
        b_hs   = bq.size() > 0 && m_axi_bvalid && s_axi_bready[hb];

        if (maw_hs) begin
            mq_id.push_back(pay.id);
            m_aw_cnt++;
            pend = 0;
        end
        if (w_hs) begin
            wbeats++;
            whold[h] = 0;
            if (beat_i[h] == int'(bur[h][w_i[h]].len)) begin
                void'(wq.pop_front());
                w_i[h]++;
                beat_i[h] = 0;
                wlast_cnt++;
            end else begin
                beat_i[h]++;
            end
        end
        if (b_hs) begin
            void'(bq.pop_front());
            chk("s_bid", 64'(s_axi_bid), 64'(bur[hb][b_i[hb]].id));
            chk("s_bresp", 64'(s_axi_bresp), 64'(cur_bresp));
            b_i[hb]++;
            bact = 0;
            b_issued++;
        end
        if (aw_hs) begin
            pay.addr  = bur[g][aw_i[g]].addr;
            pay.len   = bur[g][aw_i[g]].len;
            pay.id    = bur[g][aw_i[g]].id;
            pay.size  = 3'd3;
            pay.burst = 2'b01;
            pend      = 1;
            rr_last   = g;
            wq.push_back(g);
            bq.push_back(g);
            aw_i[g]++;
            awhold[g] = 0;
        end
    endtask

    task automatic step();
        drive();
        @(negedge aclk);
        check_update();
        @(posedge aclk);
        #1;
    endtask

    task automatic run(input string tag, input int maxc);
        int c;
        c = 0;
        while (!all_done() && c < maxc) begin
            step();
            c++;
        end
        chk(tag, 64'(all_done()), 64'd1);
    endtask

    task automatic do_reset();
        drive_idle();
        aresetn = 1'b0;
        #1;
        chk("rst_m_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_m_awaddr", 64'(m_axi_awaddr), 64'd0);
        chk("rst_m_awlen", 64'(m_axi_awlen), 64'd0);
        chk("rst_m_awid", 64'(m_axi_awid), 64'd0);
        chk("rst_m_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_m_bready", 64'(m_axi_bready), 64'd0);
        chk("rst_s_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_s_wready", 64'(s_axi_wready), 64'd0);
        chk("rst_s_bvalid", 64'(s_axi_bvalid), 64'd0);
        clear_model();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int start, c;
        n_cmp = 0; n_err = 0; wbeats = 0; dut_aw_cnt = 0;
        do_reset();

        // Simultaneous requests straight out of reset: r0 first, then r1.
        knobs(100, 100, 100, 100, 100, 100);
        gnt_log.delete();
        add(0, 32'h000, 1, {$urandom, $urandom});
        add(1, 32'h200, 1, {$urandom, $urandom});
        run("drain_both", 200);
        chk("first_gnt", 64'(gnt_log[0]), 64'd0);
        chk("second_gnt", 64'(gnt_log[1]), 64'd1);
        new_phase();

        // Single requester, 4-beat burst with data 0x11..0x44.
        add(0, 32'h100, 3, 64'h11);
        run("drain_single", 200);
        new_phase();

        // Continuous contention: grants alternate.
        for (int k = 0; k < 8; k++) begin
            add(0, 32'h1000 + 32'(k * 64), 0, {$urandom, $urandom});
            add(1, 32'h2000 + 32'(k * 64), 0, {$urandom, $urandom});
        end
        gnt_log.delete();
        start = 1 - rr_last;
        run("drain_alt", 500);
        chk("alt_count", 64'(gnt_log.size()), 64'd16);
        for (int k = 0; k < gnt_log.size() && k < 16; k++) begin
            chk("alt_gnt", 64'(gnt_log[k]), 64'((start + k) % 2));
        end
        new_phase();

        // Responses held off: only MAX_OUTSTANDING bursts get in.
        knobs(100, 100, 100, 100, 100, 0);
        for (int k = 0; k < 5; k++) begin
            add(0, 32'h3000 + 32'(k * 64), int'($urandom_range(2)),
                {$urandom, $urandom});
        end
        dut_aw_cnt = 0;
        repeat (30) step();
        chk("stall_aw_count", 64'(dut_aw_cnt), 64'd4);
        pr_br = 100;
        run("drain_stall", 300);
        chk("stall_aw_total", 64'(dut_aw_cnt), 64'd5);
        new_phase();

        // r1 offers W data before its AW while r0 has a long burst.
        knobs(100, 100, 100, 100, 100, 100);
        pr_awv[1] = 0;
        add(0, 32'h4000, 7, {$urandom, $urandom});
        add(1, 32'h5000, 1, {$urandom, $urandom});
        repeat (4) step();
        pr_awv[1] = 100;
        run("drain_early_w", 300);
        new_phase();

        // Randomized traffic with random back-pressure everywhere.
        for (int r = 0; r < 3; r++) begin
            knobs(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                  int'($urandom_range(20, 100)), int'($urandom_range(30, 100)),
                  int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
            for (int k = 0; k < 6; k++) begin
                add(0, $urandom, int'($urandom_range(7)), {$urandom, $urandom});
                add(1, $urandom, int'($urandom_range(7)), {$urandom, $urandom});
            end
            run("drain_random", 3000);
            new_phase();
        end

        // Reset in the middle of an 8-beat burst, then a clean write.
        knobs(100, 100, 100, 100, 100, 100);
        add(0, 32'h6000, 7, {$urandom, $urandom});
        wbeats = 0;
        c = 0;
        while (wbeats < 2 && c < 200) begin
            step();
            c++;
        end
        chk("mid_burst_reach", 64'(wbeats >= 2), 64'd1);
        #2;
        do_reset();
        add(0, 32'h7000, 3, {$urandom, $urandom});
        run("drain_after_reset", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
